// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS main control FSM with memory handshake watchdog
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [5:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_en,
  output logic [1:0]       o_pc_source,
  output logic             o_iord,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_reg_dst,
  output logic             o_mem_to_reg,
  output logic             o_reg_write,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic [3:0]       o_state,
  output logic             o_illegal,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_retired
);

  localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd15
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WD_W-1:0]  r_wdog;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_timeout;
  logic             w_mem_wait;

  assign w_timeout  = (r_wdog == WD_LAST) && !i_mem_ready;
  assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                      && !i_mem_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_wdog    <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_retired <= r_retired + CNT_W'(w_retire);
      // the watchdog only measures an uninterrupted stall in one memory state
      if ((w_next == r_state) && w_mem_wait)
        r_wdog <= r_wdog + WD_W'(1);
      else
        r_wdog <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    o_pc_en      = 1'b0;
    o_pc_source  = 2'd0;
    o_iord       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'd0;
    o_alu_op     = 2'b00;
    o_illegal    = 1'b0;
    o_fault      = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'd1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_en    = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        o_alu_src_b = 2'd3;
        case (i_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_REXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            o_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'd2;
        w_next      = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        o_iord     = 1'b1;
        o_mem_read = 1'b1;
        if (i_mem_ready)    w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEMWR: begin
        o_iord      = 1'b1;
        o_mem_write = 1'b1;
        if (i_mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_MEMWB: begin
        o_mem_to_reg = 1'b1;
        o_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_REXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b10;
        w_next      = S_RWB;
      end
      S_RWB: begin
        o_reg_dst   = 1'b1;
        o_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b01;
        o_pc_source = 2'd1;
        o_pc_en     = i_zero;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'd2;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        o_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        o_pc_source = 2'd2;
        o_pc_en     = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_FAULT: begin
        o_fault = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign o_state   = r_state;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  localparam int TO = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic        alu_src_a, illegal, fault;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] retired;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_pc_en(pc_en), .o_pc_source(pc_source), .o_iord(iord), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_ir_write(ir_write), .o_reg_dst(reg_dst),
    .o_mem_to_reg(mem_to_reg), .o_reg_write(reg_write), .o_alu_src_a(alu_src_a),
    .o_alu_src_b(alu_src_b), .o_alu_op(alu_op), .o_state(state), .o_illegal(illegal),
    .o_fault(fault), .o_retired(retired)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic [1:0] pcs;
    logic       iord, mr, mw, irw, rd, m2r, rw, asa;
    logic [1:0] asb, aop;
    logic       ill, flt;
  } ctl_t;

  typedef struct {
    ctl_t        c;
    logic [31:0] ret;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_retired = '0;

  function automatic bit is_legal(logic [5:0] op);
    return op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  endfunction

  // expected controls per state, straight from the state descriptions
  function automatic ctl_t exp_ctl(int st, bit rdy, bit z, logic [5:0] op);
    ctl_t c = '0;
    c.st = st[3:0];
    case (st)
      0:  begin c.mr = 1; c.asb = 2'd1; c.irw = rdy; c.pc_en = rdy; end
      1:  begin c.asb = 2'd3; c.ill = !is_legal(op); end
      2:  begin c.asa = 1; c.asb = 2'd2; end
      3:  begin c.iord = 1; c.mr = 1; end
      4:  begin c.m2r = 1; c.rw = 1; end
      5:  begin c.iord = 1; c.mw = 1; end
      6:  begin c.asa = 1; c.aop = 2'b10; end
      7:  begin c.rd = 1; c.rw = 1; end
      8:  begin c.asa = 1; c.aop = 2'b01; c.pcs = 2'd1; c.pc_en = z; end
      9:  begin c.asa = 1; c.asb = 2'd2; end
      10: begin c.rw = 1; end
      11: begin c.pcs = 2'd2; c.pc_en = 1; end
      15: begin c.flt = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic cyc(int st, bit rdy, bit rstv, logic [5:0] op);
    exp_t e;
    bit   z;
    @(posedge clk);
    #1;
    z         = 1'($urandom_range(0, 1));
    rst       = rstv;
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    e.c       = exp_ctl(st, rdy, z, op);
    e.ret     = m_retired;
    q.push_back(e);
  endtask

  task automatic mem_phase(int st, int wfix, logic [5:0] op);
    int w;
    w = (wfix >= 0) ? wfix : $urandom_range(0, TO - 1);
    repeat (w) cyc(st, 1'b0, 1'b0, op);
    cyc(st, 1'b1, 1'b0, op);
  endtask

  task automatic run_instr(logic [5:0] op, int wfix);
    int seq[$];
    case (op)
      OP_LW:   seq = '{0, 1, 2, 3, 4};
      OP_SW:   seq = '{0, 1, 2, 5};
      OP_R:    seq = '{0, 1, 6, 7};
      OP_BEQ:  seq = '{0, 1, 8};
      OP_ADDI: seq = '{0, 1, 9, 10};
      OP_J:    seq = '{0, 1, 11};
      default: seq = '{0, 1};
    endcase
    foreach (seq[i]) begin
      if (seq[i] inside {0, 3, 5}) mem_phase(seq[i], wfix, op);
      else cyc(seq[i], 1'($urandom_range(0, 1)), 1'b0, op);
    end
    if (is_legal(op)) m_retired = m_retired + 32'd1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    ctl_t a;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {state, pc_en, pc_source, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal, fault};
      checks++;
      if (a !== e.c || retired !== e.ret) begin
        failures++;
        $display("FAIL ctl_cycle t=%0t got ctl=%h st=%0d retired=%0d expected ctl=%h st=%0d retired=%0d",
                 $time, a, a.st, retired, e.c, e.c.st, e.ret);
      end
    end
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    int         k;
    ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    cyc(0, 1'b0, 1'b1, OP_R);

    run_instr(OP_LW, 0);
    run_instr(OP_SW, 3);
    run_instr(6'b111111, 0);
    run_instr(OP_BEQ, 0);
    run_instr(OP_J, 1);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 6);
      if (k < 6) begin
        op = ops[k];
      end else begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end
      run_instr(op, -1);
    end

    cyc(0, 1'b1, 1'b0, OP_R);
    cyc(1, 1'b0, 1'b0, OP_R);
    cyc(6, 1'b0, 1'b1, OP_R);
    m_retired = '0;
    cyc(0, 1'b0, 1'b1, OP_R);
    run_instr(OP_ADDI, 0);

    repeat (TO) cyc(0, 1'b0, 1'b0, OP_LW);
    repeat (5) cyc(15, 1'($urandom_range(0, 1)), 1'b0, OP_LW);
    cyc(15, 1'b0, 1'b1, OP_LW);
    m_retired = '0;
    cyc(0, 1'b0, 1'b1, OP_LW);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
